bj_bet_controller: RTL and testbench
====================================

Name: bj_bet_controller

Overview:
Sequences the betting datapath for the FPGA blackjack game. It holds registered bankroll and bet values and turns debounced button presses into single bet increments. It locks the bet when a hand is dealt and settles the bankroll when the card engine reports the outcome. Its bankroll and bet outputs drive the existing three-digit money display and two-digit bet display.

Parameters:
START_BANK, 200, bankroll value loaded at reset
MAX_BET, 99, absolute bet ceiling, set by the two-digit display
MAX_BANK, 999, bankroll saturation ceiling, set by the three-digit display
BANK_W, 10, bankroll width
BET_W, 7, bet width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
inc_1  in  1  debounced level; adds 1 to bet on rising edge
inc_5  in  1  debounced level; adds 5 to bet on rising edge
inc_10  in  1  debounced level; adds 10 to bet on rising edge
inc_25  in  1  debounced level; adds 25 to bet on rising edge
clear_bet  in  1  debounced level; zeroes bet on rising edge
deal  in  1  debounced level; commits bet on rising edge
round_done  in  1  1-cycle pulse from card engine; hand finished
outcome  in  2  valid with round_done: 00 lose, 01 push, 10 win, 11 blackjack
bankroll  out  BANK_W  current bankroll, unsigned
bet  out  BET_W  current bet
bet_locked  out  1  high while a hand is in progress
start_round  out  1  1-cycle pulse that tells the card engine to deal
game_over  out  1  high when bankroll is exhausted
state  out  2  FSM state, for debug LEDs

Behaviour:
- Reset (async, active-high): bankroll=START_BANK, bet=0, state=BETTING; bet_locked, start_round and game_over all 0. All edge-detect history registers clear to 0, so a button held through reset does not fire.
- Rising-edge detect on every button input: a press is prev=0 and cur=1. A press produces exactly one action, however long the button is held.
- States: BETTING(00), LOCKED(01), SETTLE(10), BROKE(11).
- BETTING:
  - Add the sum of all increment edges seen this cycle; simultaneous presses add together.
  - New bet = min(bet + sum, MAX_BET, bankroll). Compute the sum at BETTING width + 2 bits so it cannot wrap.
  - clear_bet edge: bet=0 next cycle. clear_bet beats any increment in the same cycle.
  - deal edge with bet>0: next cycle state=LOCKED, bankroll=bankroll-bet, bet_locked=1, start_round=1 for exactly that cycle. deal beats clear_bet and increments in the same cycle; those are dropped.
  - deal edge with bet=0: ignored, no pulse.
  - round_done in BETTING: ignored.
- LOCKED:
  - All button edges are ignored; bet holds.
  - round_done: capture outcome, go to SETTLE next cycle.
- SETTLE (exactly one cycle), credit added to bankroll:
  - lose: +0
  - push: +bet
  - win: +2*bet
  - blackjack: +bet + floor(3*bet/2)
  - The sum saturates at MAX_BANK.
  - Next cycle: bet=0, bet_locked=0. If the new bankroll is 0, go to BROKE; otherwise go to BETTING.
- BROKE: game_over=1; every input is ignored; only rst exits.
- Latency: button edge to bet update is 1 cycle. round_done to updated bankroll is 2 cycles (the capture in LOCKED, then the SETTLE update).
- Invariants:
  - bet ≤ min(MAX_BET, bankroll) whenever the state is BETTING.
  - bankroll never underflows and never exceeds MAX_BANK.
- Reset mid-round: the committed bet is forfeited and bankroll returns to START_BANK.

Decomposition:
- Shared package bj_pkg holds:
  - outcome encodings OUT_LOSE/OUT_PUSH/OUT_WIN/OUT_BJ
  - state encodings ST_BETTING/ST_LOCKED/ST_SETTLE/ST_BROKE
  - START_BANK, MAX_BET and MAX_BANK defaults
- Sub-module bj_edge_pulse: one-register rising-edge detector with async reset. Instantiate it once per button input (6 instances).
- The FSM, bet accumulator and payout adder live in bj_bet_controller.

Test Plan:
- Reset, then inc_25 pressed 4 times -> bet 25, 50, 75, then 99 (clamped); bankroll stays 200.
- Hold inc_1 high for 50 cycles -> bet increases by exactly 1.
- inc_5 and inc_10 rise in the same cycle -> bet +15. clear_bet together with inc_25 -> bet 0.
- bet=99, deal -> the next cycle shows bankroll 101, start_round high for 1 cycle, bet_locked=1. Then round_done with win -> bankroll 299, bet 0, state BETTING.
- Blackjack with odd bet 5: deal -> bankroll 195; blackjack -> 195+5+7=207. Push with bet 10 -> bankroll unchanged after settle.
- Bankroll 30: inc_25 twice -> bet 30 (bankroll cap); deal, lose -> bankroll 0, game_over=1, state BROKE; later presses ignored; rst restores 200.
- Bankroll 990 with bet 99 and blackjack -> bankroll saturates at 999. deal with bet 0 -> no start_round, state stays BETTING.

Source files
------------

// File: rtl/bj_pkg.sv
// Shared encodings and default limits for the blackjack betting datapath.
package bj_pkg;

    // Hand outcome reported by the card engine alongside round_done.
    typedef enum logic [1:0] {
        OUT_LOSE = 2'b00,
        OUT_PUSH = 2'b01,
        OUT_WIN  = 2'b10,
        OUT_BJ   = 2'b11
    } outcome_t;

    // Betting controller states; the encoding also drives the debug LEDs.
    typedef enum logic [1:0] {
        ST_BETTING = 2'b00,
        ST_LOCKED  = 2'b01,
        ST_SETTLE  = 2'b10,
        ST_BROKE   = 2'b11
    } state_t;

    localparam int DEF_START_BANK = 200;
    localparam int DEF_MAX_BET    = 99;   // two-digit bet display
    localparam int DEF_MAX_BANK   = 999;  // three-digit money display

endpackage

// File: rtl/bj_bet_controller_if.sv
// Button/card-engine inputs and display/status outputs of the bet controller.
interface bj_bet_controller_if #(
    parameter int BANK_W = 10,
    parameter int BET_W  = 7
);
    logic              inc_1;
    logic              inc_5;
    logic              inc_10;
    logic              inc_25;
    logic              clear_bet;
    logic              deal;
    logic              round_done;
    logic [1:0]        outcome;
    logic [BANK_W-1:0] bankroll;
    logic [BET_W-1:0]  bet;
    logic              bet_locked;
    logic              start_round;
    logic              game_over;
    logic [1:0]        state;

    // Driver side: buttons and card engine.
    modport master (
        output inc_1, inc_5, inc_10, inc_25, clear_bet, deal, round_done, outcome,
        input  bankroll, bet, bet_locked, start_round, game_over, state
    );

    // Controller side.
    modport slave (
        input  inc_1, inc_5, inc_10, inc_25, clear_bet, deal, round_done, outcome,
        output bankroll, bet, bet_locked, start_round, game_over, state
    );
endinterface

// File: rtl/bj_edge_pulse.sv
// Rising-edge detector for one debounced button level. History clears to 0
// on reset; the pulse is combinational so the action lands on the next edge.
module bj_edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    logic prev;

    // Remember last cycle's level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= level;
    end

    assign pulse = level & ~prev;
endmodule

// File: rtl/bj_bet_controller.sv
// Betting FSM: accumulates the bet from button presses, debits it at deal,
// and credits the payout (saturating) when the card engine finishes a hand.
module bj_bet_controller
    import bj_pkg::*;
#(
    parameter int START_BANK = DEF_START_BANK,
    parameter int MAX_BET    = DEF_MAX_BET,
    parameter int MAX_BANK   = DEF_MAX_BANK,
    parameter int BANK_W     = 10,
    parameter int BET_W      = 7
) (
    input logic clk,
    input logic rst,
    bj_bet_controller_if.slave bus
);
    localparam int SUM_W = BET_W + 2;   // room for bet + all four increments
    localparam int CR_W  = BANK_W + 2;  // room for bankroll + blackjack credit

    // Button order: inc_1, inc_5, inc_10, inc_25, clear_bet, deal.
    logic [5:0] btn;
    logic [5:0] press;

    assign btn = {bus.deal, bus.clear_bet, bus.inc_25, bus.inc_10, bus.inc_5, bus.inc_1};

    for (genvar i = 0; i < 6; i++) begin : g_edge
        bj_edge_pulse u_edge (
            .clk   (clk),
            .rst   (rst),
            .level (btn[i]),
            .pulse (press[i])
        );
    end

    state_t            state_q, state_d;
    logic [BANK_W-1:0] bankroll_q, bankroll_d;
    logic [BET_W-1:0]  bet_q, bet_d;
    logic              start_q, start_d;
    outcome_t          outcome_q, outcome_d;

    logic [SUM_W-1:0]  inc_sum;
    logic [BANK_W-1:0] bet_limit, bet_cand, bet_clamped;
    logic [CR_W-1:0]   bet_x, credit, payout;
    logic [BANK_W-1:0] settled;

    // Bet accumulation: all increment presses this cycle, clamped to the
    // display ceiling and to what the bankroll can cover.
    always_comb begin
        inc_sum = (press[0] ? SUM_W'(1)  : '0)
                + (press[1] ? SUM_W'(5)  : '0)
                + (press[2] ? SUM_W'(10) : '0)
                + (press[3] ? SUM_W'(25) : '0);
        bet_limit   = (bankroll_q < BANK_W'(MAX_BET)) ? bankroll_q : BANK_W'(MAX_BET);
        bet_cand    = BANK_W'(bet_q) + BANK_W'(inc_sum);
        bet_clamped = (bet_cand > bet_limit) ? bet_limit : bet_cand;
    end

    // Payout: credit for the captured outcome, saturated at the money display limit.
    always_comb begin
        bet_x = CR_W'(bet_q);
        case (outcome_q)
            OUT_LOSE: credit = '0;
            OUT_PUSH: credit = bet_x;
            OUT_WIN:  credit = bet_x << 1;
            OUT_BJ:   credit = bet_x + ((bet_x + (bet_x << 1)) >> 1);
            default:  credit = '0;
        endcase
        payout  = CR_W'(bankroll_q) + credit;
        settled = (payout > CR_W'(MAX_BANK)) ? BANK_W'(MAX_BANK) : payout[BANK_W-1:0];
    end

    // Next-state and datapath updates; deal beats clear, clear beats increments.
    always_comb begin
        state_d    = state_q;
        bankroll_d = bankroll_q;
        bet_d      = bet_q;
        start_d    = 1'b0;
        outcome_d  = outcome_q;
        case (state_q)
            ST_BETTING: begin
                if (press[5] && bet_q != '0) begin
                    state_d    = ST_LOCKED;
                    bankroll_d = bankroll_q - BANK_W'(bet_q);
                    start_d    = 1'b1;
                end else if (press[4]) begin
                    bet_d = '0;
                end else begin
                    bet_d = BET_W'(bet_clamped);
                end
            end
            ST_LOCKED: begin
                if (bus.round_done) begin
                    outcome_d = outcome_t'(bus.outcome);
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                bankroll_d = settled;
                bet_d      = '0;
                state_d    = (settled == '0) ? ST_BROKE : ST_BETTING;
            end
            ST_BROKE: ;
            default:  state_d = ST_BETTING;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BETTING;
            bankroll_q <= BANK_W'(START_BANK);
            bet_q      <= '0;
            start_q    <= 1'b0;
            outcome_q  <= OUT_LOSE;
        end else begin
            state_q    <= state_d;
            bankroll_q <= bankroll_d;
            bet_q      <= bet_d;
            start_q    <= start_d;
            outcome_q  <= outcome_d;
        end
    end

    assign bus.bankroll    = bankroll_q;
    assign bus.bet         = bet_q;
    assign bus.bet_locked  = (state_q == ST_LOCKED) || (state_q == ST_SETTLE);
    assign bus.start_round = start_q;
    assign bus.game_over   = (state_q == ST_BROKE);
    assign bus.state       = state_q;
endmodule

// File: tb/tb_bj_bet_controller.sv
// Directed bench for bj_bet_controller: vector table plus multi-cycle sequences.
module tb_bj_bet_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    bj_bet_controller_if #(.BANK_W(10), .BET_W(7)) bus ();

    bj_bet_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Button mask bits: 0 inc_1, 1 inc_5, 2 inc_10, 3 inc_25, 4 clear_bet, 5 deal.
    localparam logic [5:0] B_1 = 6'b000001, B_5 = 6'b000010, B_10 = 6'b000100,
                           B_25 = 6'b001000, B_CLR = 6'b010000, B_DEAL = 6'b100000;
    localparam logic [1:0] LOSE = 2'b00, PUSH = 2'b01, WIN = 2'b10, BJ = 2'b11;

    typedef struct {
        logic [5:0] btn;
        logic       rd;
        logic [1:0] oc;
        int         bank;
        int         bet;
        int         locked;
        int         start;
        int         st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [5:0] b, logic r, logic [1:0] o,
                                int bk, int bt, int lk, int sr, int s);
        vec_t v;
        v.btn = b; v.rd = r; v.oc = o; v.bank = bk; v.bet = bt;
        v.locked = lk; v.start = sr; v.st = s;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] m, input logic r, input logic [1:0] o);
        bus.inc_1      = m[0];
        bus.inc_5      = m[1];
        bus.inc_10     = m[2];
        bus.inc_25     = m[3];
        bus.clear_bet  = m[4];
        bus.deal       = m[5];
        bus.round_done = r;
        bus.outcome    = o;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic [5:0] m, input logic r, input logic [1:0] o);
        drive(m, r, o);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [5:0] m);
        step(m, 1'b0, LOSE);
        step(6'b0, 1'b0, LOSE);
    endtask

    // Deal the current bet, report the outcome, and let SETTLE complete.
    task automatic play(input logic [1:0] o);
        press(B_DEAL);
        step(6'b0, 1'b1, o);
        step(6'b0, 1'b0, LOSE);
    endtask

    task automatic do_reset();
        drive(6'b0, 1'b0, LOSE);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all(input string tag, input int bk, input int bt, input int st);
        check({tag, ".bank"},  int'(bus.bankroll), bk);
        check({tag, ".bet"},   int'(bus.bet), bt);
        check({tag, ".state"}, int'(bus.state), st);
    endtask

    initial begin
        // Vector table, starting from reset: bank 200, bet 0.
        vecs.push_back(mk(B_25,   0, LOSE, 200, 25, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 200, 25, 0, 0, 0));
        vecs.push_back(mk(B_25,   0, LOSE, 200, 50, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 200, 50, 0, 0, 0));
        vecs.push_back(mk(B_25,   0, LOSE, 200, 75, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 200, 75, 0, 0, 0));
        vecs.push_back(mk(B_25,   0, LOSE, 200, 99, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 200, 99, 0, 0, 0));
        vecs.push_back(mk(B_DEAL, 0, LOSE, 101, 99, 1, 1, 1));
        vecs.push_back(mk(6'b0,   0, LOSE, 101, 99, 1, 0, 1));
        vecs.push_back(mk(6'b0,   1, WIN,  101, 99, 1, 0, 2));
        vecs.push_back(mk(6'b0,   0, LOSE, 299,  0, 0, 0, 0));
        vecs.push_back(mk(B_5 | B_10,   0, LOSE, 299, 15, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 299, 15, 0, 0, 0));
        vecs.push_back(mk(B_CLR | B_25, 0, LOSE, 299, 0, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 299,  0, 0, 0, 0));
        vecs.push_back(mk(B_5,    0, LOSE, 299,  5, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 299,  5, 0, 0, 0));
        vecs.push_back(mk(B_DEAL, 0, LOSE, 294,  5, 1, 1, 1));
        vecs.push_back(mk(6'b0,   0, LOSE, 294,  5, 1, 0, 1));
        vecs.push_back(mk(B_25,   1, BJ,   294,  5, 1, 0, 2));
        vecs.push_back(mk(6'b0,   0, LOSE, 306,  0, 0, 0, 0));
        vecs.push_back(mk(B_10,   0, LOSE, 306, 10, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 306, 10, 0, 0, 0));
        vecs.push_back(mk(B_DEAL, 0, LOSE, 296, 10, 1, 1, 1));
        vecs.push_back(mk(6'b0,   0, LOSE, 296, 10, 1, 0, 1));
        vecs.push_back(mk(6'b0,   1, PUSH, 296, 10, 1, 0, 2));
        vecs.push_back(mk(6'b0,   0, LOSE, 306,  0, 0, 0, 0));
        vecs.push_back(mk(B_DEAL, 0, LOSE, 306,  0, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 306,  0, 0, 0, 0));
        vecs.push_back(mk(6'b0,   1, WIN,  306,  0, 0, 0, 0));
        vecs.push_back(mk(B_1,    0, LOSE, 306,  1, 0, 0, 0));
        vecs.push_back(mk(6'b0,   0, LOSE, 306,  1, 0, 0, 0));
        vecs.push_back(mk(B_DEAL | B_5, 0, LOSE, 305, 1, 1, 1, 1));
        vecs.push_back(mk(6'b0,   0, LOSE, 305,  1, 1, 0, 1));
        vecs.push_back(mk(6'b0,   1, LOSE, 305,  1, 1, 0, 2));
        vecs.push_back(mk(6'b0,   0, LOSE, 305,  0, 0, 0, 0));

        drive(6'b0, 1'b0, LOSE);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check_all("reset", 200, 0, 0);
        check("reset.locked", int'(bus.bet_locked), 0);
        check("reset.start",  int'(bus.start_round), 0);
        check("reset.over",   int'(bus.game_over), 0);

        foreach (vecs[i]) begin
            step(vecs[i].btn, vecs[i].rd, vecs[i].oc);
            check($sformatf("vec%0d.bank", i),   int'(bus.bankroll),    vecs[i].bank);
            check($sformatf("vec%0d.bet", i),    int'(bus.bet),         vecs[i].bet);
            check($sformatf("vec%0d.locked", i), int'(bus.bet_locked),  vecs[i].locked);
            check($sformatf("vec%0d.start", i),  int'(bus.start_round), vecs[i].start);
            check($sformatf("vec%0d.state", i),  int'(bus.state),       vecs[i].st);
        end

        // Held button: exactly one increment over 50 cycles.
        for (int i = 0; i < 50; i++) step(B_1, 1'b0, LOSE);
        check("hold.bet", int'(bus.bet), 1);
        step(6'b0, 1'b0, LOSE);
        check("hold.release_bet", int'(bus.bet), 1);

        // Run the bankroll down to 30, then to 0.
        do_reset();
        repeat (4) press(B_25);
        play(LOSE);
        check_all("broke.r1", 101, 0, 0);
        press(B_25); press(B_25); press(B_10); press(B_10); press(B_1);
        check("broke.bet71", int'(bus.bet), 71);
        play(LOSE);
        check_all("broke.r2", 30, 0, 0);
        press(B_25);
        press(B_25);
        check("broke.bank_cap", int'(bus.bet), 30);
        play(LOSE);
        check_all("broke.r3", 0, 0, 3);
        check("broke.over", int'(bus.game_over), 1);
        step(B_25, 1'b0, LOSE);
        check("broke.inc_ignored", int'(bus.bet), 0);
        step(6'b0, 1'b0, LOSE);
        step(B_DEAL, 1'b0, LOSE);
        check("broke.no_start", int'(bus.start_round), 0);
        step(6'b0, 1'b1, WIN);
        step(6'b0, 1'b0, LOSE);
        check_all("broke.held", 0, 0, 3);
        do_reset();
        check_all("broke.rst", 200, 0, 0);
        check("broke.rst_over", int'(bus.game_over), 0);

        // Reset mid-round forfeits the committed bet.
        press(B_25);
        press(B_DEAL);
        check_all("midrst.locked", 175, 25, 1);
        do_reset();
        check_all("midrst.after", 200, 0, 0);
        check("midrst.unlocked", int'(bus.bet_locked), 0);

        // Climb to 990, then blackjack saturates at 999.
        for (int r = 0; r < 7; r++) begin
            repeat (4) press(B_25);
            play(WIN);
        end
        check_all("sat.climb", 893, 0, 0);
        repeat (3) press(B_25);
        press(B_10); press(B_10); press(B_1); press(B_1);
        check("sat.bet97", int'(bus.bet), 97);
        play(WIN);
        check_all("sat.990", 990, 0, 0);
        repeat (4) press(B_25);
        press(B_DEAL);
        check_all("sat.dealt", 891, 99, 1);
        step(6'b0, 1'b1, BJ);
        check_all("sat.settle", 891, 99, 2);
        step(6'b0, 1'b0, LOSE);
        check_all("sat.999", 999, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
